// File: rtl/comp_pkg.sv
// Shared types and sizing helpers for the serial magnitude comparator.
package comp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    function automatic int ndig_of(input int width, input int digit);
        return width / digit;
    endfunction

    function automatic int idx_width(input int ndig);
        return (ndig > 1) ? $clog2(ndig) : 1;
    endfunction

endpackage

// File: rtl/comp_serial_digit.sv
// One-digit unsigned comparator; invert_msb gives the two's-complement view
// of the top digit by flipping its sign bit on both operands.
module comp_digit
    import comp_pkg::*;
#(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] i_a,
    input  logic [DIGIT-1:0] i_b,
    input  logic             i_invert_msb,
    output logic             o_eq,
    output logic             o_gt,
    output logic             o_lt
);

    logic [DIGIT-1:0] w_mask;
    logic [DIGIT-1:0] w_a;
    logic [DIGIT-1:0] w_b;

    always_comb begin
        w_mask            = '0;
        w_mask[DIGIT-1]   = i_invert_msb;
    end

    assign w_a  = i_a ^ w_mask;
    assign w_b  = i_b ^ w_mask;
    assign o_eq = (w_a == w_b);
    assign o_gt = (w_a > w_b);
    assign o_lt = (w_a < w_b);

endmodule

// File: rtl/comp_serial.sv
// Multi-cycle MSB-first magnitude comparator with early termination
// on the first differing digit; start/busy/done handshake.
module comp_serial
    import comp_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             AeqB,
    output logic             AgtB,
    output logic             AltB
);

    localparam int NDIG = ndig_of(WIDTH, DIGIT);
    localparam int IW   = idx_width(NDIG);

    state_t           r_state;
    logic [IW-1:0]    r_idx;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_sgn;
    logic             r_done;
    logic             r_eq;
    logic             r_gt;
    logic             r_lt;

    logic [DIGIT-1:0] w_da;
    logic [DIGIT-1:0] w_db;
    logic             w_inv;
    logic             w_eq;
    logic             w_gt;
    logic             w_lt;

    always_comb begin
        w_da = '0;
        w_db = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (r_idx == IW'(i)) begin
                w_da = r_a[i*DIGIT +: DIGIT];
                w_db = r_b[i*DIGIT +: DIGIT];
            end
        end
    end

    // Only the top digit carries the sign bit.
    assign w_inv = r_sgn && (r_idx == IW'(NDIG-1));

    comp_digit #(
        .DIGIT (DIGIT)
    ) u_digit (
        .i_a          (w_da),
        .i_b          (w_db),
        .i_invert_msb (w_inv),
        .o_eq         (w_eq),
        .o_gt         (w_gt),
        .o_lt         (w_lt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_sgn   <= 1'b0;
            r_done  <= 1'b0;
            r_eq    <= 1'b0;
            r_gt    <= 1'b0;
            r_lt    <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a     <= A;
                        r_b     <= B;
                        r_sgn   <= signed_mode;
                        r_idx   <= IW'(NDIG-1);
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (!w_eq) begin
                        r_eq    <= 1'b0;
                        r_gt    <= w_gt;
                        r_lt    <= w_lt;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else if (r_idx == '0) begin
                        r_eq    <= 1'b1;
                        r_gt    <= 1'b0;
                        r_lt    <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_idx <= r_idx - IW'(1);
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy = (r_state != IDLE);
    assign done = r_done;
    assign AeqB = r_eq;
    assign AgtB = r_gt;
    assign AltB = r_lt;

endmodule

// File: tb/tb_comp_serial.sv
// Self-checking bench for comp_serial: directed table, corner sequences
// and a randomized run against an arithmetic reference model.
module tb_comp_serial;

    localparam int W    = 16;
    localparam int D    = 4;
    localparam int NDIG = W / D;

    localparam logic [2:0] R_EQ = 3'b100;
    localparam logic [2:0] R_GT = 3'b010;
    localparam logic [2:0] R_LT = 3'b001;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         signed_mode = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         busy, done, AeqB, AgtB, AltB;

    int errors = 0;
    int checks = 0;

    comp_serial #(.WIDTH(W), .DIGIT(D)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .signed_mode (signed_mode),
        .A           (A),
        .B           (B),
        .busy        (busy),
        .done        (done),
        .AeqB        (AeqB),
        .AgtB        (AgtB),
        .AltB        (AltB)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;
        int           k;
        logic [2:0]   res;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [2:0] ref_res(input logic [W-1:0] a,
                                           input logic [W-1:0] b,
                                           input logic s);
        int ia, ib;
        if (s) begin
            ia = int'($signed(a));
            ib = int'($signed(b));
        end else begin
            ia = int'({16'd0, a});
            ib = int'({16'd0, b});
        end
        if (ia > ib) return R_GT;
        if (ia < ib) return R_LT;
        return R_EQ;
    endfunction

    function automatic int ref_k(input logic [W-1:0] a, input logic [W-1:0] b);
        for (int d = NDIG - 1; d >= 0; d--) begin
            if (((int'(a) >> (D * d)) & 15) != ((int'(b) >> (D * d)) & 15))
                return NDIG - d;
        end
        return NDIG;
    endfunction

    function automatic logic [2:0] outs();
        return {AeqB, AgtB, AltB};
    endfunction

    task automatic run_cmp(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic s, output int k,
                           output logic [2:0] r, output int bcnt);
        bit got;
        @(negedge clk);
        A = a;
        B = b;
        signed_mode = s;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        A = ~a;
        B = ~b;
        signed_mode = ~s;
        got = 0;
        k = -1;
        r = 3'b000;
        bcnt = 0;
        for (int c = 0; c < NDIG + 3; c++) begin
            if (!got) begin
                @(negedge clk);
                if (busy) bcnt++;
                if (done) begin
                    got = 1;
                    k = c;
                    r = outs();
                end
            end
        end
        chk("done_seen", int'(got), 1);
        @(negedge clk);
        chk("done_one_cycle", int'(done), 0);
        chk("idle_after_done", int'(busy), 0);
        chk("result_held", int'(outs()), int'(r));
    endtask

    vec_t vecs[$];
    int k, bc, pulses;
    logic [2:0] r;

    initial begin
        vecs.push_back('{16'h1234, 16'h1234, 1'b0, 4, R_EQ});
        vecs.push_back('{16'h8000, 16'h7FFF, 1'b0, 1, R_GT});
        vecs.push_back('{16'h8000, 16'h7FFF, 1'b1, 1, R_LT});
        vecs.push_back('{16'hFFFF, 16'h0001, 1'b1, 1, R_LT});
        vecs.push_back('{16'h12F0, 16'h12E0, 1'b0, 3, R_GT});
        vecs.push_back('{16'h7FFF, 16'h8000, 1'b1, 1, R_GT});
        vecs.push_back('{16'h0000, 16'h0001, 1'b1, 4, R_LT});
        vecs.push_back('{16'hFFFE, 16'hFFFF, 1'b1, 4, R_LT});

        #12;
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_results", int'(outs()), 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            run_cmp(vecs[i].a, vecs[i].b, vecs[i].s, k, r, bc);
            chk($sformatf("vec%0d_k", i), k, vecs[i].k);
            chk($sformatf("vec%0d_res", i), int'(r), int'(vecs[i].res));
            chk($sformatf("vec%0d_busy", i), bc, vecs[i].k + 1);
        end

        // second start while busy is ignored
        @(negedge clk);
        A = 16'h0001;
        B = 16'h0002;
        signed_mode = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1 A = 16'h0005;
        B = 16'h0001;
        @(posedge clk);
        #1 start = 1'b0;
        pulses = 0;
        k = -1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (done) begin
                pulses++;
                if (k < 0) begin
                    k = c + 1;
                    r = outs();
                end
            end
        end
        chk("ignore_k", k, 4);
        chk("ignore_res", int'(r), int'(R_LT));
        chk("ignore_pulses", pulses, 1);

        // reset mid-compare
        @(negedge clk);
        A = 16'h0001;
        B = 16'h0002;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_results", int'(outs()), 0);
        pulses = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        chk("midrst_no_done", pulses, 0);
        rst_n = 1'b1;
        run_cmp(16'h00A0, 16'h00A0, 1'b0, k, r, bc);
        chk("post_rst_k", k, 4);
        chk("post_rst_res", int'(r), int'(R_EQ));

        // start held high, operands changing every cycle
        begin
            int e, acc, due, nxt, ndone;
            logic [2:0] er;
            logic [W-1:0] ra, rb;
            e = 0;
            acc = -10;
            due = -10;
            nxt = 1;
            ndone = 0;
            er = 3'b000;
            @(negedge clk);
            A = 16'h1111;
            B = 16'h1111;
            signed_mode = 1'b0;
            start = 1'b1;
            while (ndone < 1000 && e < 20000) begin
                @(posedge clk);
                e++;
                if (e == nxt) begin
                    acc = e;
                    due = e + ref_k(A, B);
                    nxt = due + 2;
                    er = ref_res(A, B, signed_mode);
                end
                #1;
                ra = W'($urandom);
                case ($urandom_range(0, 3))
                    0: rb = ra;
                    1: rb = W'($urandom);
                    default: rb = ra ^ W'(int'($urandom_range(1, 15))
                                        << (D * int'($urandom_range(0, NDIG - 1))));
                endcase
                A = ra;
                B = rb;
                signed_mode = 1'($urandom);
                @(negedge clk);
                chk("rand_busy", int'(busy), int'(e >= acc && e <= due));
                chk("rand_done", int'(done), int'(e == due));
                if (e == due) begin
                    chk("rand_res", int'(outs()), int'(er));
                    ndone++;
                end
            end
            start = 1'b0;
            chk("rand_count", ndone, 1000);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
